if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS CPU.
- Master of the instruction-memory read interface: holds the PC, drives the word address to the combinational instruction ROM and takes back the 32-bit instruction.
- Computes next-PC from sequential, branch and jump sources and owns the IF/ID pipeline register.
- Handles load-use stalls and control-hazard flushes requested by the ID stage.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INST, 32'h00000000, instruction word inserted into IF/ID on reset or flush (sll $0,$0,0).

Ports:
Clk  input  1  rising-edge clock.
Rst  input  1  synchronous, active-high reset.
Stall  input  1  hold PC and IF/ID (load-use hazard from ID).
BranchTaken  input  1  beq/bne resolved taken in ID this cycle.
BranchTarget  input  32  byte address of the branch target.
Jump  input  1  J decoded in ID this cycle.
JumpTarget  input  32  byte address of the jump target, already formed as {PC4[31:28], imm26, 2'b00}.
ImemAddr  output  32  byte address to the instruction ROM.
ImemInst  input  32  instruction returned by the ROM, same cycle.
PC  output  32  current fetch PC.
IfIdPc4  output  32  registered PC+4 of the instruction in IF/ID.
IfIdInst  output  32  registered instruction to ID.
IfIdValid  output  1  1 = IF/ID holds a real fetched instruction.
FetchCount  output  32  number of instructions accepted into IF/ID since reset.

Behaviour:
- ImemAddr = PC, purely combinational. The ROM read is zero-latency, so ImemInst is sampled at the same rising edge.
- Reset values (Rst=1 at an edge):
  - PC = RESET_PC
  - IfIdInst = NOP_INST
  - IfIdPc4 = 0
  - IfIdValid = 0
  - FetchCount = 0
  - Rst overrides every other input.
- Redirect = BranchTaken | Jump.
- Next-PC priority at each edge (highest first):
  1. Rst: RESET_PC.
  2. BranchTaken: BranchTarget.
  3. Jump: JumpTarget.
  4. Stall: PC (hold).
  5. Otherwise: PC+4.
- Redirect targets have bits [1:0] forced to 0 before loading the PC.
- PC+4 is a modulo-2^32 add: 32'hFFFFFFFC wraps to 32'h00000000 with no flag.
- IF/ID update at each edge (same priority):
  - Redirect (flush; no delay slot, the instruction fetched this cycle is squashed): IfIdInst = NOP_INST, IfIdValid = 0, IfIdPc4 = 0.
  - Else Stall: all IF/ID fields hold their values.
  - Else load: IfIdInst = ImemInst, IfIdPc4 = PC+4, IfIdValid = 1.
- Redirect with Stall: redirect wins. PC takes the target and IF/ID is flushed. The stall request is dropped because the stalled successor is being squashed.
- BranchTaken with Jump in the same cycle: the branch wins, and Jump is ignored for that cycle.
- FetchCount increments by 1 exactly on edges where the IF/ID load case occurs. It wraps modulo 2^32 and holds on stall or flush.
- Undefined (X) ROM words are passed through unchanged. The stage does no decoding and raises no error.
- Reset mid-operation: takes effect on the next edge regardless of Stall or redirect. The first post-reset fetch is at RESET_PC.
- One PC register, one IF/ID register set, one counter. No other state.

Test Plan:
- Reset then release, ROM loaded with the CPU test program (addi $1,$0,8 at 0x00; ori $2,$0,12 at 0x04) -> in reset cycle PC=0, IfIdInst=0, IfIdValid=0. After 1st free edge: PC=0x04, IfIdInst=0x20010008, IfIdPc4=0x04, IfIdValid=1, FetchCount=1. After 2nd edge: IfIdInst=0x3402000C.
- At PC=0x3C, assert Stall for 2 cycles -> PC stays 0x3C, IfIdInst/IfIdPc4/FetchCount unchanged for both cycles. After release, the next edge loads ImemInst from 0x3C and PC=0x40.
- BranchTaken=1, BranchTarget=0x28 while PC=0x1C -> next PC=0x28, IfIdInst=0, IfIdValid=0, FetchCount unchanged. The following edge loads the ROM word at 0x28 (0x0800000D), IfIdPc4=0x2C.
- BranchTaken=1 (target 0x40), Jump=1 (target 0x34) and Stall=1 in the same cycle -> PC=0x40, IF/ID flushed. Separately, BranchTarget=0x43 -> PC=0x40.
- Force PC to 0xFFFFFFFC via Jump (JumpTarget=0xFFFFFFFC), then run free -> next PC=0x00000000, IfIdPc4=0x00000000.
- Rst pulsed for one cycle while Stall=1 and PC=0x44 -> PC=RESET_PC, IfIdValid=0, FetchCount=0 on that edge. Normal fetch from 0x00 resumes on the next edge.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID pipeline register
// and a counter of instructions accepted into IF/ID.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemInst,
  output logic [31:0] PC,
  output logic [31:0] IfIdPc4,
  output logic [31:0] IfIdInst,
  output logic        IfIdValid,
  output logic [31:0] FetchCount
);

  logic [31:0] r_pc;
  logic [31:0] r_ifid_pc4;
  logic [31:0] r_ifid_inst;
  logic        r_ifid_valid;
  logic [31:0] r_fetch_count;

  logic        w_redirect;
  logic [31:0] w_pc4;
  logic [31:0] w_target;

  assign w_redirect = BranchTaken | Jump;
  assign w_pc4      = r_pc + 32'd4;
  // Branch beats jump; redirect targets are forced word-aligned.
  assign w_target   = BranchTaken ? {BranchTarget[31:2], 2'b00} : {JumpTarget[31:2], 2'b00};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_pc          <= RESET_PC;
      r_ifid_pc4    <= 32'h0;
      r_ifid_inst   <= NOP_INST;
      r_ifid_valid  <= 1'b0;
      r_fetch_count <= 32'h0;
    end else if (w_redirect) begin
      // Flush: the instruction fetched this cycle is squashed, stall is dropped.
      r_pc         <= w_target;
      r_ifid_pc4   <= 32'h0;
      r_ifid_inst  <= NOP_INST;
      r_ifid_valid <= 1'b0;
    end else if (!Stall) begin
      r_pc          <= w_pc4;
      r_ifid_pc4    <= w_pc4;
      r_ifid_inst   <= ImemInst;
      r_ifid_valid  <= 1'b1;
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign ImemAddr   = r_pc;
  assign PC         = r_pc;
  assign IfIdPc4    = r_ifid_pc4;
  assign IfIdInst   = r_ifid_inst;
  assign IfIdValid  = r_ifid_valid;
  assign FetchCount = r_fetch_count;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized redirect/stall/reset
// traffic, checked every cycle against a behavioural model of the stage.
module tb_if_fetch_stage;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        Jump = 1'b0;
  logic [31:0] JumpTarget = 32'h0;
  logic [31:0] ImemAddr;
  logic [31:0] ImemInst;
  logic [31:0] PC;
  logic [31:0] IfIdPc4;
  logic [31:0] IfIdInst;
  logic        IfIdValid;
  logic [31:0] FetchCount;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  logic [31:0] rom [256];

  // Behavioural model state
  logic [31:0] m_pc, m_pc4, m_inst, m_cnt;
  logic        m_valid;

  if_fetch_stage dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Stall       (Stall),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .Jump        (Jump),
    .JumpTarget  (JumpTarget),
    .ImemAddr    (ImemAddr),
    .ImemInst    (ImemInst),
    .PC          (PC),
    .IfIdPc4     (IfIdPc4),
    .IfIdInst    (IfIdInst),
    .IfIdValid   (IfIdValid),
    .FetchCount  (FetchCount)
  );

  always #5 Clk = ~Clk;

  assign ImemInst = rom[ImemAddr[9:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: next state from the stage's priority rules, ROM read from the model's own PC.
  always @(posedge Clk) begin
    if (Rst) begin
      m_pc <= 32'h0; m_pc4 <= 32'h0; m_inst <= 32'h0; m_valid <= 1'b0; m_cnt <= 32'h0;
    end else if (BranchTaken || Jump) begin
      m_pc    <= (BranchTaken ? BranchTarget : JumpTarget) & 32'hFFFF_FFFC;
      m_pc4   <= 32'h0;
      m_inst  <= 32'h0;
      m_valid <= 1'b0;
    end else if (!Stall) begin
      m_inst  <= rom[m_pc[9:2]];
      m_pc4   <= m_pc + 32'd4;
      m_pc    <= m_pc + 32'd4;
      m_valid <= 1'b1;
      m_cnt   <= m_cnt + 32'd1;
    end
  end

  // Compare process
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("pc", PC, m_pc);
      chk("imem_addr", ImemAddr, m_pc);
      chk("ifid_pc4", IfIdPc4, m_pc4);
      chk("ifid_inst", IfIdInst, m_inst);
      chk("ifid_valid", {31'h0, IfIdValid}, {31'h0, m_valid});
      chk("fetch_count", FetchCount, m_cnt);
    end
  end

  task automatic cyc(input bit rst, input bit st, input bit bt, input logic [31:0] btg,
                     input bit j, input logic [31:0] jtg);
    Rst = rst; Stall = st; BranchTaken = bt; BranchTarget = btg; Jump = j; JumpTarget = jtg;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] held_inst;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0]  = 32'h2001_0008;
    rom[1]  = 32'h3402_000C;
    rom[10] = 32'h0800_000D;

    @(negedge Clk);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_en = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rst_pc", PC, 32'h0);
    chk("rst_inst", IfIdInst, 32'h0);
    chk("rst_valid", {31'h0, IfIdValid}, 32'h0);

    run(1);
    chk("f1_pc", PC, 32'h4);
    chk("f1_inst", IfIdInst, 32'h2001_0008);
    chk("f1_pc4", IfIdPc4, 32'h4);
    chk("f1_valid", {31'h0, IfIdValid}, 32'h1);
    chk("f1_cnt", FetchCount, 32'h1);
    run(1);
    chk("f2_inst", IfIdInst, 32'h3402_000C);

    run(13);
    chk("pre_stall_pc", PC, 32'h3C);
    held_inst = IfIdInst;
    chk("pre_stall_inst", held_inst, rom[14]);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk("stall_pc", PC, 32'h3C);
      chk("stall_inst", IfIdInst, rom[14]);
      chk("stall_pc4", IfIdPc4, 32'h3C);
      chk("stall_cnt", FetchCount, 32'd15);
    end
    run(1);
    chk("post_stall_inst", IfIdInst, rom[15]);
    chk("post_stall_pc", PC, 32'h40);
    chk("post_stall_cnt", FetchCount, 32'd16);

    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1C);
    chk("jmp_pc", PC, 32'h1C);
    cyc(1'b0, 1'b0, 1'b1, 32'h28, 1'b0, 32'h0);
    chk("br_pc", PC, 32'h28);
    chk("br_inst", IfIdInst, 32'h0);
    chk("br_valid", {31'h0, IfIdValid}, 32'h0);
    chk("br_cnt", FetchCount, 32'd16);
    run(1);
    chk("br_tgt_inst", IfIdInst, 32'h0800_000D);
    chk("br_tgt_pc4", IfIdPc4, 32'h2C);

    cyc(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h34);
    chk("brjs_pc", PC, 32'h40);
    chk("brjs_valid", {31'h0, IfIdValid}, 32'h0);
    chk("brjs_pc4", IfIdPc4, 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 32'h43, 1'b0, 32'h0);
    chk("br_align_pc", PC, 32'h40);

    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    chk("wrap_jmp_pc", PC, 32'hFFFF_FFFC);
    run(1);
    chk("wrap_pc", PC, 32'h0);
    chk("wrap_pc4", IfIdPc4, 32'h0);
    chk("wrap_valid", {31'h0, IfIdValid}, 32'h1);

    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h44);
    chk("pre_rst_pc", PC, 32'h44);
    cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("mid_rst_pc", PC, 32'h0);
    chk("mid_rst_valid", {31'h0, IfIdValid}, 32'h0);
    chk("mid_rst_cnt", FetchCount, 32'h0);
    run(1);
    chk("resume_pc", PC, 32'h4);
    chk("resume_inst", IfIdInst, 32'h2001_0008);
    chk("resume_cnt", FetchCount, 32'h1);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(63) == 0), ($urandom_range(3) == 0), ($urandom_range(7) == 0),
          $urandom, ($urandom_range(7) == 0), $urandom);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
